// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divider sequencer.
//
// Contents:
//   div_state_e                        FSM state encoding (DivFree/DivByZero/DivOn/DivEnd)
//   DivResultReady/DivResultNotReady   values driven on ready_o
//   DivStart/DivStop                   values seen on start_i
//   StallBusW                          width of the pipeline stall bus
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam int StallBusW = 6;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring-division step, purely combinational.
//
// Ports:
//   rem_dvd       {partial remainder, dividend being shifted out}
//   divisor       divisor magnitude
//   rem_dvd_next  {rem, dividend} after shift (and subtract); LSB left as 0
//   q_bit         quotient bit produced by this step
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] rem_dvd,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] rem_dvd_next,
  output logic                q_bit
);

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;

  // The shifted remainder can need one extra bit before the compare; once it
  // is known to be >= divisor the difference always fits back in DATA_W bits.
  always_comb begin
    trial        = rem_dvd[2*DATA_W-1:DATA_W-1];
    diff         = trial[DATA_W-1:0] - divisor;
    q_bit        = (trial >= {1'b0, divisor});
    rem_dvd_next = {rem_dvd[2*DATA_W-2:0], 1'b0};
    if (q_bit) begin
      rem_dvd_next[2*DATA_W-1:DATA_W] = diff;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the iterative shift-subtract divider serving DIV/DIVU.
// Produces one quotient bit per cycle, applies the sign fixup and holds
// the pipeline through stallreq_for_ex until the result is valid.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start_i             divide instruction present in EX
//   signed_div_i        1 = DIV, 0 = DIVU
//   opdata1_i/2_i       dividend / divisor
//   annul_i             cancel the operation in flight
//   result_o            {remainder, quotient}, registered
//   ready_o             result valid this cycle
//   stallreq_for_ex     stall request to the stall controller
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_for_ex
);

  div_state_e state, state_next;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem, dvd, dsr;
  logic                neg_quot, neg_rem;
  logic                load_ops, do_step, load_result;
  logic [2*DATA_W-1:0] result_next;
  logic [2*DATA_W-1:0] step_next;
  logic                q_bit;
  logic [DATA_W-1:0]   quot_raw, rem_raw, op1_abs, op2_abs;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_dvd      ({rem, dvd}),
    .divisor      (dsr),
    .rem_dvd_next (step_next),
    .q_bit        (q_bit)
  );

  assign quot_raw = step_next[DATA_W-1:0] | DATA_W'(q_bit);
  assign rem_raw  = step_next[2*DATA_W-1:DATA_W];

  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Stall is dropped in DivEnd so the pipeline moves on exactly when the
  // result is presented.
  assign stallreq_for_ex = rst & start_i & ~annul_i & (state != DivEnd);
  assign ready_o         = (state == DivEnd) ? DivResultReady : DivResultNotReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DivFree;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath controls. annul_i overrides everything; losing
  // start_i mid-operation means the instruction was flushed, so abort too.
  // The result is computed from the final step so it is loaded on the very
  // edge that enters DivEnd.
  always_comb begin
    state_next  = state;
    load_ops    = 1'b0;
    do_step     = 1'b0;
    load_result = 1'b0;
    result_next = result_o;
    if (annul_i) begin
      state_next = DivFree;
    end else begin
      case (state)
        DivFree: begin
          if (start_i == DivStart) begin
            load_ops   = 1'b1;
            state_next = (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (start_i == DivStop) begin
            state_next = DivFree;
          end else begin
            state_next  = DivEnd;
            load_result = 1'b1;
            result_next = {dvd, {DATA_W{1'b1}}};
          end
        end
        DivOn: begin
          if (start_i == DivStop) begin
            state_next = DivFree;
          end else begin
            do_step = 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state_next  = DivEnd;
              load_result = 1'b1;
              result_next = {neg_rem  ? -rem_raw  : rem_raw,
                             neg_quot ? -quot_raw : quot_raw};
            end
          end
        end
        DivEnd:  state_next = DivFree;
        default: state_next = DivFree;
      endcase
    end
  end

  // Operand, iteration and result registers. A zero divisor keeps the raw
  // dividend because that is what the divide-by-zero result reports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
    end else begin
      if (load_ops) begin
        dvd      <= (opdata2_i == '0) ? opdata1_i : op1_abs;
        dsr      <= op2_abs;
        rem      <= '0;
        cnt      <= '0;
        neg_quot <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
        neg_rem  <= signed_div_i & opdata1_i[DATA_W-1];
      end else if (do_step) begin
        rem <= rem_raw;
        dvd <= quot_raw;
        cnt <= cnt + CNT_W'(1);
      end
      if (load_result) begin
        result_o <= result_next;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: expected results are queued when a
// divide is launched and compared whenever ready_o is seen.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_for_ex;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expQ[$];
  logic [63:0] lastExp;

  div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .signed_div_i    (signed_div_i),
    .opdata1_i       (opdata1_i),
    .opdata2_i       (opdata2_i),
    .annul_i         (annul_i),
    .result_o        (result_o),
    .ready_o         (ready_o),
    .stallreq_for_ex (stallreq_for_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference divide using 64-bit signed arithmetic, so the
  // 0x80000000 / -1 case cannot overflow in the model.
  function automatic logic [63:0] modelDiv(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = {32'd0, a} / {32'd0, b};
      r = {32'd0, a} % {32'd0, b};
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Called just after a rising edge; that cycle becomes cycle 0.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input bit expectResult);
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    if (expectResult) begin
      lastExp = modelDiv(sgn, a, b);
      expQ.push_back(lastExp);
    end
  endtask

  task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int expLat, input string tag);
    int   cyc;
    logic seen;
    logic stallOk;
    applyStimulus(sgn, a, b, 1'b1);
    cyc     = 0;
    seen    = 1'b0;
    stallOk = 1'b1;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (ready_o) begin
        seen = 1'b1;
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
        checkOutput({tag, "_stall_at_ready"}, 64'(stallreq_for_ex), 64'd0);
      end else begin
        if (!stallreq_for_ex) stallOk = 1'b0;
        cyc++;
        @(posedge clk);
        #1;
      end
    end
    if (!seen) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    checkOutput({tag, "_stall_busy"}, 64'(stallOk), 64'd1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Scoreboard: every ready_o pops one expected result.
  always @(negedge clk) begin
    if (rst && ready_o) begin
      if (expQ.size() == 0) begin
        checkOutput("stale_ready", 64'd1, 64'd0);
      end else begin
        checkOutput("result", result_o, expQ.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst          = 1'b0;
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd5;
    opdata2_i    = 32'd1;
    annul_i      = 1'b0;
    lastExp      = 64'd0;

    #3;
    checkOutput("reset_ready", 64'(ready_o), 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    checkOutput("reset_stall", 64'(stallreq_for_ex), 64'd0);
    start_i = 1'b0;
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] unsigned and signed divides");
    runDiv(1'b0, 32'd100, 32'd7, 33, "divu_100_7");
    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 33, "div_m7_2");
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_ovf");
    runDiv(1'b1, 32'd100, 32'hFFFF_FFF9, 33, "div_100_m7");
    runDiv(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "divu_big");

    $display("[TB] divide by zero");
    runDiv(1'b0, 32'h0000_1234, 32'd0, 2, "divzero");

    $display("[TB] back-to-back");
    runDiv(1'b0, 32'd10, 32'd3, 33, "b2b_first");
    runDiv(1'b0, 32'd9, 32'd2, 33, "b2b_second");

    $display("[TB] random operands");
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = 32'($urandom_range(1, 5000));
      rs = 1'($urandom_range(0, 1));
      if (rs && $urandom_range(0, 1) == 1) rb = -rb;
      runDiv(rs, ra, rb, 33, "random");
    end

    $display("[TB] annul mid-operation");
    applyStimulus(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul_stall", 64'(stallreq_for_ex), 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("annul_ready", 64'(ready_o), 64'd0);
    checkOutput("annul_stall_after", 64'(stallreq_for_ex), 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("annul_hold", result_o, lastExp);
    @(posedge clk);
    #1;
    runDiv(1'b0, 32'd77, 32'd5, 33, "after_annul");

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(1'b1, 32'hFFFF_FFCE, 32'd7, 1'b0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_ready", 64'(ready_o), 64'd0);
    checkOutput("rst_result", result_o, 64'd0);
    checkOutput("rst_stall", 64'(stallreq_for_ex), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("rst_idle_result", result_o, 64'd0);
    checkOutput("rst_idle_ready", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1;
    runDiv(1'b0, 32'd100, 32'd7, 33, "after_reset");

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
